alu_exec: RTL

//  Multi-cycle execute stage that consumes the 4x8-bit register file's read

---
 rtl/alu_exec.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_exec.sv
// ---------------------------------------------------------------------------
// alu_exec : multi-cycle execute stage for a small register-file machine.
//
// One instruction is accepted per start pulse while idle. The operands are
// read through the register file read ports in EXEC, and the result is
// produced there. MUL instead runs an 8-cycle shift-add loop. The result
// is written back through the register file write port in WB, and the
// zero/carry flags are updated on the same edge that ends WB.
//
// Ports
//   clk    in   1      clock, rising edge
//   rst    in   1      synchronous reset, active-low
//   start  in   1      instruction request, honoured only while idle
//   op     in   3      opcode (ADD SUB AND OR XOR SHL MUL LDI)
//   ra     in   SEL_W  source A register select
//   rb     in   SEL_W  source B register select
//   rd     in   SEL_W  destination register select
//   imm    in   WIDTH  immediate operand for LDI
//   aout   in   WIDTH  register file read data A (combinational from asel)
//   bout   in   WIDTH  register file read data B (combinational from bsel)
//   asel   out  SEL_W  register file read select A (valid in EXEC)
//   bsel   out  SEL_W  register file read select B (valid in EXEC)
//   csel   out  SEL_W  register file write select (valid in WB)
//   cin    out  WIDTH  register file write data (valid in WB)
//   cload  out  1      register file write enable, one-cycle pulse
//   busy   out  1      instruction in flight
//   done   out  1      completion pulse, coincident with cload
//   zero   out  1      result of last completed op was zero
//   carry  out  1      carry/borrow/overflow of last completed op
// ---------------------------------------------------------------------------
module alu_exec #(
   parameter int WIDTH = 8,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [SEL_W-1:0] ra,
   input  logic [SEL_W-1:0] rb,
   input  logic [SEL_W-1:0] rd,
   input  logic [WIDTH-1:0] imm,
   input  logic [WIDTH-1:0] aout,
   input  logic [WIDTH-1:0] bout,
   output logic [SEL_W-1:0] asel,
   output logic [SEL_W-1:0] bsel,
   output logic [SEL_W-1:0] csel,
   output logic [WIDTH-1:0] cin,
   output logic             cload,
   output logic             busy,
   output logic             done,
   output logic             zero,
   output logic             carry
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_XOR = 3'b100;
   localparam logic [2:0] OP_SHL = 3'b101;
   localparam logic [2:0] OP_MUL = 3'b110;
   localparam logic [2:0] OP_LDI = 3'b111;

   localparam int             CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_MUL  = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t state_q, state_d;

   // latched instruction
   logic [2:0]       op_q;
   logic [SEL_W-1:0] ra_q, rb_q, rd_q;
   logic [WIDTH-1:0] imm_q;

   // pending result and its carry, published to the flags in WB
   logic [WIDTH-1:0] res_q;
   logic             cres_q;

   // shift-add multiplier state
   logic [2*WIDTH-1:0] mcand_q;
   logic [WIDTH-1:0]   mplr_q;
   logic [2*WIDTH-1:0] acc_q;
   logic [CNT_W-1:0]   cnt_q;

   logic zero_q, carry_q;

   // Single-cycle ALU: returns {carry, result}. MUL is handled by the
   // iterative datapath and never selects this result.
   function automatic logic [WIDTH:0] alu_f(input logic [2:0]       f_op,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b,
                                            input logic [WIDTH-1:0] im);
      logic [WIDTH:0] r;
      r = '0;
      case (f_op)
         OP_ADD:  r = {1'b0, a} + {1'b0, b};
         OP_SUB:  r = {(a < b), a - b};
         OP_AND:  r = {1'b0, a & b};
         OP_OR:   r = {1'b0, a | b};
         OP_XOR:  r = {1'b0, a ^ b};
         OP_SHL:  r = {a[WIDTH-1], a << 1};
         OP_LDI:  r = {1'b0, im};
         default: r = '0;
      endcase
      return r;
   endfunction

   logic [WIDTH:0]     alu_r;
   logic [2*WIDTH-1:0] mul_addend;
   logic [2*WIDTH-1:0] acc_sum;

   always_comb begin
      alu_r      = alu_f(op_q, aout, bout, imm_q);
      mul_addend = mplr_q[0] ? mcand_q : '0;
      acc_sum    = acc_q + mul_addend;
   end

   // ---- state register ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---- next state and outputs ----
   always_comb begin
      state_d = state_q;
      asel    = '0;
      bsel    = '0;
      csel    = '0;
      cin     = '0;
      cload   = 1'b0;
      done    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_EXEC;
         end
         S_EXEC: begin
            asel    = ra_q;
            bsel    = rb_q;
            state_d = (op_q == OP_MUL) ? S_MUL : S_WB;
         end
         S_MUL: begin
            if (cnt_q == CNT_LAST) state_d = S_WB;
         end
         S_WB: begin
            cload   = 1'b1;
            done    = 1'b1;
            csel    = rd_q;
            cin     = res_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy  = (state_q != S_IDLE);
   assign zero  = zero_q;
   assign carry = carry_q;

   // ---- datapath: accept, execute, multiply loop, flag update ----
   always_ff @(posedge clk) begin
      if (!rst) begin
         op_q    <= '0;
         ra_q    <= '0;
         rb_q    <= '0;
         rd_q    <= '0;
         imm_q   <= '0;
         res_q   <= '0;
         cres_q  <= 1'b0;
         mcand_q <= '0;
         mplr_q  <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         zero_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  op_q  <= op;
                  ra_q  <= ra;
                  rb_q  <= rb;
                  rd_q  <= rd;
                  imm_q <= imm;
               end
            end
            S_EXEC: begin
               if (op_q == OP_MUL) begin
                  mcand_q <= {{WIDTH{1'b0}}, aout};
                  mplr_q  <= bout;
                  acc_q   <= '0;
                  cnt_q   <= '0;
               end else begin
                  res_q  <= alu_r[WIDTH-1:0];
                  cres_q <= alu_r[WIDTH];
               end
            end
            S_MUL: begin
               acc_q   <= acc_sum;
               mcand_q <= mcand_q << 1;
               mplr_q  <= mplr_q >> 1;
               cnt_q   <= cnt_q + 1'b1;
               // last iteration: the sum just formed is the full product
               if (cnt_q == CNT_LAST) begin
                  res_q  <= acc_sum[WIDTH-1:0];
                  cres_q <= |acc_sum[2*WIDTH-1:WIDTH];
               end
            end
            S_WB: begin
               zero_q  <= (res_q == '0);
               carry_q <= cres_q;
            end
            default: ;
         endcase
      end
   end

endmodule
